// File: rtl/regfile_port_sequencer.sv
// Register file port sequencer: takes one command per handshake and drives
// the single-ported register file strobes, capturing operands and counting completions.
// Ports: clk/rst_n; req_valid/req_ready/req_cmd/req_ra/req_rb/req_wdata command side;
// resp_valid/op_a/op_b/done_cnt result side; rf_din/read/readu/write/writeu/inc/dec/id/dout rf side.
module regfile_port_sequencer #(
  parameter int DATA_W = 16,
  parameter int ID_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_cmd,
  input  logic [ID_W-1:0]   req_ra,
  input  logic [ID_W-1:0]   req_rb,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [15:0]       done_cnt,
  output logic [DATA_W-1:0] rf_din,
  output logic              rf_read,
  output logic              rf_readu,
  output logic              rf_write,
  output logic              rf_writeu,
  output logic              rf_inc,
  output logic              rf_dec,
  output logic [ID_W-1:0]   rf_id,
  input  logic [DATA_W-1:0] rf_dout
);

  localparam logic [2:0] C_RD1 = 3'b000;
  localparam logic [2:0] C_RD2 = 3'b001;
  localparam logic [2:0] C_WR  = 3'b010;
  localparam logic [2:0] C_WRU = 3'b011;
  localparam logic [2:0] C_INC = 3'b100;
  localparam logic [2:0] C_DEC = 3'b101;
  localparam logic [2:0] C_POP = 3'b110;
  localparam logic [2:0] C_RDU = 3'b111;

  typedef enum logic [2:0] {
    IDLE, RD_A, RD_B, EXEC, DONE
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          cmd_q, cmd_d;
  logic [ID_W-1:0]     ra_q, ra_d;
  logic [ID_W-1:0]     rb_q, rb_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   op_a_q, op_a_d;
  logic [DATA_W-1:0]   op_b_q, op_b_d;
  logic [15:0]         cnt_q, cnt_d;

  logic accept;
  logic is_read_cmd;

  assign accept = (state_q == IDLE) && req_valid;

  assign is_read_cmd = (req_cmd == C_RD1) || (req_cmd == C_RD2) ||
                       (req_cmd == C_RDU) || (req_cmd == C_POP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      wdata_q <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      wdata_q <= wdata_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      cnt_q   <= cnt_d;
    end
  end

  // next state and register updates
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    wdata_d = wdata_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          cmd_d   = req_cmd;
          ra_d    = req_ra;
          rb_d    = req_rb;
          wdata_d = req_wdata;
          state_d = is_read_cmd ? RD_A : EXEC;
        end
      end
      RD_A: begin
        op_a_d = rf_dout;
        unique case (1'b1)
          cmd_q == C_RD2: state_d = RD_B;
          cmd_q == C_POP: state_d = EXEC;
          default:        state_d = DONE;
        endcase
      end
      RD_B: begin
        op_b_d  = rf_dout;
        state_d = DONE;
      end
      EXEC: state_d = DONE;
      DONE: begin
        cnt_d   = cnt_q + 16'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Moore rf strobes, decoded only from state and latched command
  always_comb begin
    rf_din    = '0;
    rf_read   = 1'b0;
    rf_readu  = 1'b0;
    rf_write  = 1'b0;
    rf_writeu = 1'b0;
    rf_inc    = 1'b0;
    rf_dec    = 1'b0;
    rf_id     = '0;
    unique case (state_q)
      RD_A: begin
        rf_id = ra_q;
        if (cmd_q == C_RDU) rf_readu = 1'b1;
        else                rf_read  = 1'b1;
      end
      RD_B: begin
        rf_id   = rb_q;
        rf_read = 1'b1;
      end
      EXEC: begin
        rf_id = ra_q;
        unique case (1'b1)
          cmd_q == C_WR: begin
            rf_write = 1'b1;
            rf_din   = wdata_q;
          end
          cmd_q == C_WRU: begin
            rf_writeu = 1'b1;
            rf_din    = {{(DATA_W-8){1'b0}}, wdata_q[7:0]};
          end
          cmd_q == C_INC,
          cmd_q == C_POP: rf_inc = 1'b1;
          cmd_q == C_DEC: rf_dec = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == DONE);
  assign op_a       = op_a_q;
  assign op_b       = op_b_q;
  assign done_cnt   = cnt_q;

endmodule

// File: tb/tb_regfile_port_sequencer.sv
// Bench for regfile_port_sequencer paired with a behavioural register file:
// directed command steps with a response scoreboard, reset abort, random stream.
module tb_regfile_port_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_cmd = '0;
  logic [4:0]  req_ra = '0;
  logic [4:0]  req_rb = '0;
  logic [15:0] req_wdata = '0;
  logic        resp_valid;
  logic [15:0] op_a, op_b, done_cnt;
  logic [15:0] rf_din;
  logic        rf_read, rf_readu, rf_write, rf_writeu, rf_inc, rf_dec;
  logic [4:0]  rf_id;
  logic [15:0] rf_dout;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_cnt = '0;

  typedef struct {
    bit          chk;
    logic [15:0] a;
    logic [15:0] b;
  } resp_t;
  resp_t sb[$];

  always #5 clk = ~clk;

  regfile_port_sequencer #(.DATA_W(16), .ID_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_ra(req_ra), .req_rb(req_rb),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .op_a(op_a), .op_b(op_b),
    .done_cnt(done_cnt),
    .rf_din(rf_din), .rf_read(rf_read), .rf_readu(rf_readu),
    .rf_write(rf_write), .rf_writeu(rf_writeu),
    .rf_inc(rf_inc), .rf_dec(rf_dec),
    .rf_id(rf_id), .rf_dout(rf_dout)
  );

  // behavioural register file
  logic [15:0] regs [32];

  always_comb begin
    rf_dout = '0;
    if (rf_read)       rf_dout = regs[rf_id];
    else if (rf_readu) rf_dout = {8'h00, regs[rf_id][15:8]};
  end

  always @(posedge clk) begin
    if (rf_write)  regs[rf_id] <= rf_din;
    if (rf_writeu) regs[rf_id][15:8] <= rf_din[7:0];
    if (rf_inc)    regs[rf_id] <= regs[rf_id] + 16'd1;
    if (rf_dec)    regs[rf_id] <= regs[rf_id] - 16'd1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // strobe invariants, every cycle out of reset
  always @(negedge clk) begin
    if (rst_n) begin
      chk("onehot", 32'($countones({rf_read, rf_readu, rf_write,
                                    rf_writeu, rf_inc, rf_dec}) <= 1), 32'd1);
      if (!(rf_write || rf_writeu)) chk("din_idle", 32'(rf_din), 32'd0);
    end
  end

  function automatic int lat_of(input logic [2:0] c);
    return (c == 3'b001 || c == 3'b110) ? 3 : 2;
  endfunction

  int last_wr_cycles;
  logic [4:0] last_wr_id;

  task automatic do_cmd(input logic [2:0] c, input logic [4:0] ra,
                        input logic [4:0] rb, input logic [15:0] wd,
                        input bit ck, input logic [15:0] ea,
                        input logic [15:0] eb);
    resp_t e;
    resp_t g;
    int lat;
    int nstb;
    bit got;
    @(negedge clk);
    chk("ready_idle", 32'(req_ready), 32'd1);
    chk("done_cnt", 32'(done_cnt), 32'(exp_cnt));
    req_valid = 1'b1;
    req_cmd   = c;
    req_ra    = ra;
    req_rb    = rb;
    req_wdata = wd;
    e.chk = ck;
    e.a   = ea;
    e.b   = eb;
    sb.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_cmd   = $urandom_range(0, 7);
    req_ra    = $urandom_range(0, 31);
    req_rb    = $urandom_range(0, 31);
    req_wdata = 16'($urandom);
    lat = 0;
    nstb = 0;
    got = 0;
    last_wr_cycles = 0;
    last_wr_id = '0;
    while (!got && lat < 8) begin
      @(negedge clk);
      lat++;
      nstb += 32'($countones({rf_read, rf_readu, rf_write,
                              rf_writeu, rf_inc, rf_dec}));
      if (rf_write) begin
        last_wr_cycles++;
        last_wr_id = rf_id;
      end
      if (resp_valid) got = 1;
      else if (req_ready) chk("ready_busy", 32'(req_ready), 32'd0);
    end
    if (!got) begin
      chk("resp_timeout", 32'(lat), 32'(lat_of(c)));
    end else begin
      chk("ready_done", 32'(req_ready), 32'd0);
      chk("latency", 32'(lat), 32'(lat_of(c)));
      chk("strobes", 32'(nstb), 32'(lat_of(c) - 1));
      g = sb.pop_front();
      if (g.chk) begin
        chk("op_a", 32'(op_a), 32'(g.a));
        chk("op_b", 32'(op_b), 32'(g.b));
      end
      exp_cnt = exp_cnt + 16'd1;
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp", 32'(resp_valid), 32'd0);
    chk("rst_strobes", 32'({rf_read, rf_readu, rf_write, rf_writeu,
                            rf_inc, rf_dec}), 32'd0);
    chk("rst_id", 32'(rf_id), 32'd0);
    chk("rst_din", 32'(rf_din), 32'd0);
    chk("rst_op_a", 32'(op_a), 32'd0);
    chk("rst_op_b", 32'(op_b), 32'd0);
    chk("rst_cnt", 32'(done_cnt), 32'd0);
    rst_n = 1'b1;

    do_cmd(3'b010, 5'd1, 5'd0, 16'h0F0F, 0, '0, '0);
    chk("wr_cycles", 32'(last_wr_cycles), 32'd1);
    chk("wr_id", 32'(last_wr_id), 32'd1);
    do_cmd(3'b000, 5'd1, 5'd0, 16'h0, 1, 16'h0F0F, 16'h0000);

    do_cmd(3'b010, 5'd0, 5'd0, 16'h1F0F, 0, '0, '0);
    do_cmd(3'b011, 5'd0, 5'd0, 16'h00F3, 0, '0, '0);
    do_cmd(3'b000, 5'd0, 5'd0, 16'h0, 1, 16'hF30F, 16'h0000);
    do_cmd(3'b111, 5'd0, 5'd0, 16'h0, 1, 16'h00F3, 16'h0000);

    do_cmd(3'b010, 5'd2, 5'd0, 16'hFFFF, 0, '0, '0);
    do_cmd(3'b100, 5'd2, 5'd0, 16'h0, 0, '0, '0);
    do_cmd(3'b000, 5'd2, 5'd0, 16'h0, 1, 16'h0000, 16'h0000);
    do_cmd(3'b101, 5'd2, 5'd0, 16'h0, 0, '0, '0);
    do_cmd(3'b000, 5'd2, 5'd0, 16'h0, 1, 16'hFFFF, 16'h0000);

    do_cmd(3'b010, 5'd3, 5'd0, 16'h1234, 0, '0, '0);
    do_cmd(3'b010, 5'd4, 5'd0, 16'hABCD, 0, '0, '0);
    do_cmd(3'b001, 5'd3, 5'd4, 16'h0, 1, 16'h1234, 16'hABCD);
    do_cmd(3'b001, 5'd3, 5'd3, 16'h0, 1, 16'h1234, 16'h1234);

    do_cmd(3'b010, 5'd5, 5'd0, 16'h0010, 0, '0, '0);
    do_cmd(3'b110, 5'd5, 5'd0, 16'h0, 1, 16'h0010, 16'h1234);
    do_cmd(3'b000, 5'd5, 5'd0, 16'h0, 1, 16'h0011, 16'h1234);

    for (int i = 0; i < 40; i++) begin
      do_cmd(3'($urandom_range(0, 7)), 5'($urandom_range(6, 31)),
             5'($urandom_range(0, 31)), 16'($urandom), 0, '0, '0);
    end

    // abort an RD2 while it sits in RD_B
    @(negedge clk);
    chk("cnt_before_rst", 32'(done_cnt), 32'(exp_cnt));
    req_valid = 1'b1;
    req_cmd   = 3'b001;
    req_ra    = 5'd3;
    req_rb    = 5'd4;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rdb_read", 32'(rf_read), 32'd1);
    chk("rdb_id", 32'(rf_id), 32'd4);
    rst_n = 1'b0;
    #1;
    chk("abort_strobes", 32'({rf_read, rf_readu, rf_write, rf_writeu,
                              rf_inc, rf_dec}), 32'd0);
    chk("abort_ready", 32'(req_ready), 32'd1);
    chk("abort_resp", 32'(resp_valid), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_resp", 32'(resp_valid), 32'd0);
    end
    rst_n = 1'b1;
    exp_cnt = '0;
    repeat (2) begin
      @(negedge clk);
      chk("post_rst_resp", 32'(resp_valid), 32'd0);
      chk("post_rst_ready", 32'(req_ready), 32'd1);
    end
    chk("post_rst_op_a", 32'(op_a), 32'd0);
    chk("post_rst_op_b", 32'(op_b), 32'd0);
    do_cmd(3'b000, 5'd3, 5'd0, 16'h0, 1, 16'h1234, 16'h0000);
    @(negedge clk);
    chk("final_cnt", 32'(done_cnt), 32'(exp_cnt));
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
